// File: rtl/vm_keypad_pkg.sv
// Shared types and constants for the vending-machine keypad scanner.
// Holds the FSM and scan-result encodings, row drive patterns and named key codes.
package vm_keypad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS_DB, ST_PRESSED, ST_REL_DB} kp_state_e;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_res_t;

  // lows saturates at 2: a second contact already makes the scan MULTI
  typedef struct packed {
    logic [1:0] lows;
    logic [3:0] code;
  } scan_acc_t;

  localparam logic [3:0] ROW_DRIVE_0 = 4'b1110;
  localparam logic [3:0] ROW_DRIVE_1 = 4'b1101;
  localparam logic [3:0] ROW_DRIVE_2 = 4'b1011;
  localparam logic [3:0] ROW_DRIVE_3 = 4'b0111;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [3:0] KEY_CANCEL  = 4'hB;
  localparam logic [3:0] KEY_GOODS1  = 4'hC;
  localparam logic [3:0] KEY_GOODS2  = 4'hD;
  localparam logic [3:0] KEY_COIN    = 4'hE;
  localparam logic [3:0] KEY_CLEAR   = 4'hF;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW_DRIVE_0;
      2'd1:    r = ROW_DRIVE_1;
      2'd2:    r = ROW_DRIVE_2;
      default: r = ROW_DRIVE_3;
    endcase
    return r;
  endfunction

  function automatic scan_acc_t acc_add(input scan_acc_t acc, input logic [1:0] row,
                                        input logic [3:0] col_n);
    scan_acc_t r;
    r = acc;
    for (int c = 0; c < 4; c++) begin
      if (!col_n[c]) begin
        if (r.lows == 2'd0) r.code = {row, 2'(c)};
        if (r.lows != 2'd2) r.lows = r.lows + 2'd1;
      end
    end
    return r;
  endfunction

  function automatic scan_res_t classify(input scan_acc_t acc);
    scan_res_t r;
    r.code = acc.code;
    case (acc.lows)
      2'd0:    r.kind = SCAN_NONE;
      2'd1:    r.kind = SCAN_SINGLE;
      default: r.kind = SCAN_MULTI;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Latency 2 cycles, no flow control; synchronous active-low reset to RST_VAL.
module sync_2ff #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with whole-scan debounce and one-cycle key events.
// Event lags a stable contact by up to one partial scan, DEBOUNCE_SCANS scans and 2 sync cycles; no backpressure.
module keypad_scan
  import vm_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 99_999,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic [3:0] col_s;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_col_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_col),
    .q     (col_s)
  );

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_row_q, key_row_d;
  scan_acc_t        acc_q, acc_d, acc_next;
  kp_state_e        state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             tick, end_scan;
  scan_res_t        res;

  always_comb begin
    tick        = (div_q == DIV_TC);
    end_scan    = tick && (row_idx_q == 2'd3);
    acc_next    = acc_add(acc_q, row_idx_q, col_s);
    res         = classify(acc_next);

    div_d       = tick ? '0 : div_q + 1'b1;
    row_idx_d   = row_idx_q;
    key_row_d   = key_row_q;
    acc_d       = acc_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    // The row sampled on this tick has been driven for the whole step just ending
    if (tick) begin
      row_idx_d = row_idx_q + 2'd1;
      key_row_d = row_drive(row_idx_d);
      acc_d     = end_scan ? '0 : acc_next;
    end

    if (end_scan) begin
      case (state_q)
        ST_IDLE: begin
          if (res.kind == SCAN_SINGLE) begin
            cand_d = res.code;
            if (DB_N <= 4'd1) begin
              state_d     = ST_PRESSED;
              cnt_d       = '0;
              key_code_d  = res.code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_PRESS_DB: begin
          if (res.kind == SCAN_SINGLE && res.code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_N) begin
              state_d     = ST_PRESSED;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (res.kind == SCAN_NONE) begin
            if (DB_N <= 4'd1) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_REL_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        default: begin
          if (res.kind == SCAN_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_N) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_q       <= '0;
      row_idx_q   <= '0;
      key_row_q   <= ROW_DRIVE_0;
      acc_q       <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      key_row_q   <= key_row_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_row   = key_row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a contact-matrix keypad model plus a scan-level reference
// built from the sampling, classification and debounce rules; checked every cycle.
module tb_keypad_scan;

  localparam int SD = 3;
  localparam int DB = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] contact;     // bit r*4+c closes row r to column c
  int checks, failures;
  int k, k0;
  int m_ph, m_cnt, m_cand, m_lows, m_code;
  logic e_valid, e_held;
  logic [3:0] e_code;
  logic [3:0] hist[$];
  int pulses, last_pulse_k, held_fall_k;
  logic prev_held;
  logic [3:0] rows_exp [4];
  int kind, ka, kb, len;
  logic bnc;
  logic [15:0] target;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  function automatic logic [3:0] col_of(input logic [15:0] ct, input logic [3:0] rows);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (ct[r*4+c] && !rows[r]) v[c] = 1'b0;
    return v;
  endfunction

  assign key_col = col_of(contact, key_row);

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column value seen at edge j is hist[j-1]; a tick at edge k decides on the edge k-2 value.
  task automatic model_tick();
    int row;
    logic [3:0] s;
    row = (k / 4 - 1) % 4;
    s = hist[k-3];
    for (int c = 0; c < 4; c++)
      if (!s[c]) begin
        if (m_lows == 0) m_code = row * 4 + c;
        m_lows++;
      end
    if (k % 16 == 0) begin
      case (m_ph)
        0: if (m_lows == 1) begin m_cand = m_code; m_ph = 1; m_cnt = 1; end
        1: if (m_lows == 1 && m_code == m_cand) begin
             m_cnt++;
             if (m_cnt == DB) begin
               m_ph = 2; m_cnt = 0; e_valid = 1'b1; e_code = 4'(m_cand); e_held = 1'b1;
             end
           end else begin m_ph = 0; m_cnt = 0; end
        2: if (m_lows == 0) begin m_ph = 3; m_cnt = 1; end
        default: if (m_lows == 0) begin
             m_cnt++;
             if (m_cnt == DB) begin m_ph = 0; m_cnt = 0; e_held = 1'b0; end
           end else begin m_ph = 2; m_cnt = 0; end
      endcase
      m_lows = 0;
    end
  endtask

  task automatic step();
    hist.push_back(col_of(contact, key_row));
    @(posedge sys_clk);
    k++;
    e_valid = 1'b0;
    if (k % 4 == 0) model_tick();
    @(negedge sys_clk);
    chk("key_row", 32'(key_row), 32'(rows_exp[(k/4)%4]));
    chk("key_valid", 32'(key_valid), 32'(e_valid));
    chk("key_held", 32'(key_held), 32'(e_held));
    chk("key_code", 32'(key_code), 32'(e_code));
    if (key_valid === 1'b1) begin pulses++; last_pulse_k = k; end
    if (prev_held === 1'b1 && key_held === 1'b0) held_fall_k = k;
    prev_held = key_held;
  endtask

  task automatic do_reset(input int n);
    sys_rst_n = 1'b0;
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_row", 32'(key_row), 32'h0000_000E);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    k = 0; hist.delete();
    m_ph = 0; m_cnt = 0; m_cand = 0; m_lows = 0; m_code = 0;
    e_valid = 1'b0; e_held = 1'b0; e_code = 4'h0; prev_held = 1'b0;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    rows_exp[0] = 4'b1110; rows_exp[1] = 4'b1101;
    rows_exp[2] = 4'b1011; rows_exp[3] = 4'b0111;
    checks = 0; failures = 0; contact = 16'h0; sys_rst_n = 1'b0;
    pulses = 0; last_pulse_k = -1; held_fall_k = -1;
    do_reset(3);

    // idle keypad
    repeat (64) step();
    chk("idle_pulses", 32'(pulses), 32'd0);

    // clean press of row 2 / col 1
    k0 = k; pulses = 0; contact = 16'h0200;
    repeat (160) step();
    chk("press_pulses", 32'(pulses), 32'd1);
    chk("press_time", 32'(last_pulse_k - k0), 32'd64);
    chk("press_code", 32'(key_code), 32'h9);
    chk("press_held", 32'(key_held), 32'h1);

    // release: 2 clean scans, 1 bouncing scan, 4 clean scans
    k0 = k; pulses = 0; held_fall_k = -1; contact = 16'h0;
    repeat (32) step();
    contact = 16'h0200;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) contact = contact ^ 16'h0200;
      step();
    end
    contact = 16'h0;
    repeat (80) step();
    chk("rel_fall_time", 32'(held_fall_k - k0), 32'd112);
    chk("rel_pulses", 32'(pulses), 32'd0);

    // two keys together, then drop one
    pulses = 0; contact = 16'h8001;
    repeat (128) step();
    chk("multi_pulses", 32'(pulses), 32'd0);
    k0 = k; contact = 16'h0001;
    repeat (96) step();
    chk("single_after_multi", 32'(pulses), 32'd1);
    chk("single_time", 32'(last_pulse_k - k0), 32'd64);
    chk("single_code", 32'(key_code), 32'h0);
    contact = 16'h0;
    repeat (96) step();
    chk("single_released", 32'(key_held), 32'h0);

    // bouncing press for 2 scans, then stable
    k0 = k; pulses = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 3 == 0) contact = contact ^ 16'h0200;
      step();
    end
    contact = 16'h0200;
    repeat (96) step();
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_code", 32'(key_code), 32'h9);
    chk("bounce_not_early", 32'(last_pulse_k - k0 >= 64), 32'd1);
    chk("bounce_not_late", 32'(last_pulse_k - k0 <= 96), 32'd1);
    contact = 16'h0;
    repeat (96) step();

    // reset while the press debounce count is at 3
    pulses = 0; contact = 16'h0200;
    repeat (53) step();
    chk("pre_rst_pulses", 32'(pulses), 32'd0);
    do_reset(1);
    repeat (96) step();
    chk("post_rst_pulses", 32'(pulses), 32'd1);
    chk("post_rst_time", 32'(last_pulse_k), 32'd64);
    contact = 16'h0;
    repeat (96) step();

    // randomized contact patterns, changing at arbitrary cycles
    for (int seg = 0; seg < 40; seg++) begin
      kind = int'($urandom_range(0, 3));
      ka   = int'($urandom_range(0, 15));
      kb   = (ka + int'($urandom_range(1, 15))) % 16;
      len  = int'($urandom_range(8, 120));
      bnc  = ($urandom_range(0, 3) == 0);
      case (kind)
        0:       target = 16'h0;
        3:       target = (16'h1 << ka) | (16'h1 << kb);
        default: target = 16'h1 << ka;
      endcase
      for (int i = 0; i < len; i++) begin
        if (bnc && i < 24) contact = (i % 6 < 3) ? target : 16'h0;
        else contact = target;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
